// File: rtl/pld_fifo_arbiter_pkg.sv
// Shared types and helpers for the payload-FIFO round-robin arbiter.
// Holds the FSM encoding, the round-robin search and the counter-width helper.
package pld_fifo_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned MAX_SRC  = 8;
  localparam int unsigned MAX_ID_W = 3;

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(v)) r = k + 1;
    end
    return r;
  endfunction

  // First set request after 'last', wrapping modulo num; returns 'last' if none.
  function automatic logic [MAX_ID_W-1:0] rr_next(input logic [MAX_SRC-1:0]  req,
                                                  input logic [MAX_ID_W-1:0] last,
                                                  input int unsigned         num);
    logic [MAX_ID_W-1:0] pick;
    int unsigned         idx;
    pick = last;
    // Walk from the farthest candidate down so the nearest one wins.
    for (int unsigned k = MAX_SRC; k >= 1; k--) begin
      if (k <= num) begin
        idx = (32'(last) + k) % num;
        if (req[idx[MAX_ID_W-1:0]]) pick = MAX_ID_W'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pld_fifo_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: winner index after last_grant, plus any-request flag.
module pld_fifo_arbiter_rr_priority_picker
  import pld_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner_c,
  output logic               any_req_c
);

  logic [MAX_SRC-1:0]  req_ext;
  logic [MAX_ID_W-1:0] pick;

  assign req_ext   = MAX_SRC'(req);
  assign pick      = rr_next(req_ext, MAX_ID_W'(last_grant), NUM_SRC);
  assign winner_c  = ID_W'(pick);
  assign any_req_c = |req;

endmodule

// File: rtl/pld_fifo_arbiter.sv
// Round-robin arbiter sharing the payload FIFO write port among sources, one record per grant.
// Optional statistics counters built when PLD_FIFO_ARBITER_STATS_EN is defined.
module pld_fifo_arbiter
  import pld_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned WORD_WIDTH   = 64,
  parameter int unsigned BURST_WORDS  = 2,
  parameter int unsigned SRC_ID_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_rdy,
  input  logic                          arb_enable,
  output logic [WORD_WIDTH-1:0]         pld_fifo_din,
  output logic                          pld_fifo_wr,
  input  logic                          pld_fifo_full,
  output logic [SRC_ID_WIDTH-1:0]       grant_id,
  output logic                          busy,
  output logic [31:0]                   records_granted,
  output logic [31:0]                   stall_cycles
);

  localparam int unsigned             CNT_W     = clog2_u(BURST_WORDS) + 1;
  localparam logic [CNT_W-1:0]        LAST_WORD = CNT_W'(BURST_WORDS - 1);
  localparam logic [SRC_ID_WIDTH-1:0] LAST_SRC  = SRC_ID_WIDTH'(NUM_SRC - 1);

  state_e                  state, state_nxt;
  logic [SRC_ID_WIDTH-1:0] grant_q, grant_nxt;
  logic [SRC_ID_WIDTH-1:0] last_grant, last_grant_nxt;
  logic [CNT_W-1:0]        word_cnt, word_cnt_nxt;
  logic [SRC_ID_WIDTH-1:0] winner;
  logic                    any_req;
  logic                    start;
  logic                    in_burst;
  logic                    sel_valid;
  logic [WORD_WIDTH-1:0]   sel_data;
  logic                    xfer;

  pld_fifo_arbiter_rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (SRC_ID_WIDTH)
  ) u_rr_priority_picker (
    .req        (src_valid),
    .last_grant (last_grant),
    .winner_c   (winner),
    .any_req_c  (any_req)
  );

  // Select the granted source's valid and word.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRC_ID_WIDTH'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign start    = arb_enable & any_req;
  assign in_burst = (state == BURST) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= LAST_SRC;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    word_cnt_nxt   = word_cnt;
    xfer           = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = BURST;
          grant_nxt      = winner;
          last_grant_nxt = winner;
          word_cnt_nxt   = '0;
        end
      end
      BURST: begin
        // Grant is held through valid gaps so a record is never split.
        xfer = sel_valid & ~pld_fifo_full & ~reset;
        if (xfer) begin
          if (word_cnt == LAST_WORD) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
          end else begin
            word_cnt_nxt = word_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_rdy = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_rdy[i] = xfer & (grant_q == SRC_ID_WIDTH'(i));
    end
  end

  assign pld_fifo_wr  = xfer;
  assign pld_fifo_din = in_burst ? sel_data : '0;
  assign grant_id     = grant_q;
  assign busy         = in_burst;

`ifdef PLD_FIFO_ARBITER_STATS_EN
  logic [31:0] rec_cnt;
  logic [31:0] stall_cnt;
  logic        stall;

  assign stall = (state == BURST) & sel_valid & pld_fifo_full;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == IDLE) && start && (rec_cnt != 32'hFFFF_FFFF)) rec_cnt <= rec_cnt + 32'd1;
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign records_granted = rec_cnt;
  assign stall_cycles    = stall_cnt;
`else
  assign records_granted = '0;
  assign stall_cycles    = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(pld_fifo_wr && pld_fifo_full)) else $error("pld_fifo_wr while pld_fifo_full");
      assert ($onehot0(src_rdy)) else $error("multiple src_rdy bits high");
    end
  end
`endif

endmodule

// File: tb/tb_pld_fifo_arbiter.sv
// Scoreboard bench for pld_fifo_arbiter: directed scenarios on the default build
// plus a randomized NUM_SRC=3 / BURST_WORDS=1 instance.
module tb_pld_fifo_arbiter;

`ifdef PLD_FIFO_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [255:0] src_data;
  logic [3:0]   src_valid;
  logic [3:0]   src_rdy;
  logic         arb_enable;
  logic [63:0]  pld_fifo_din;
  logic         pld_fifo_wr;
  logic         pld_fifo_full;
  logic [1:0]   grant_id;
  logic         busy;
  logic [31:0]  records_granted;
  logic [31:0]  stall_cycles;

  logic         r_reset;
  logic [191:0] r_data;
  logic [2:0]   r_valid;
  logic [2:0]   r_rdy;
  logic [63:0]  r_din;
  logic         r_wr;
  logic         r_full;
  logic [1:0]   r_grant;
  logic         r_busy;
  logic [31:0]  r_records;
  logic [31:0]  r_stalls;

  pld_fifo_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_rdy         (src_rdy),
    .arb_enable      (arb_enable),
    .pld_fifo_din    (pld_fifo_din),
    .pld_fifo_wr     (pld_fifo_wr),
    .pld_fifo_full   (pld_fifo_full),
    .grant_id        (grant_id),
    .busy            (busy),
    .records_granted (records_granted),
    .stall_cycles    (stall_cycles)
  );

  pld_fifo_arbiter #(
    .NUM_SRC      (3),
    .WORD_WIDTH   (64),
    .BURST_WORDS  (1),
    .SRC_ID_WIDTH (2)
  ) dut3 (
    .clk             (clk),
    .reset           (r_reset),
    .src_data        (r_data),
    .src_valid       (r_valid),
    .src_rdy         (r_rdy),
    .arb_enable      (1'b1),
    .pld_fifo_din    (r_din),
    .pld_fifo_wr     (r_wr),
    .pld_fifo_full   (r_full),
    .grant_id        (r_grant),
    .busy            (r_busy),
    .records_granted (r_records),
    .stall_cycles    (r_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] send_q [4][$];
  logic [63:0] exp_q  [4][$];
  logic [1:0]  exp_grant_q [$];
  logic [3:0]  en_mask;
  logic        drv_reset, drv_full, drv_en;
  logic        busy_prev;
  int          burst_cnt;
  logic [1:0]  burst_src;
  int          n_checks, n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_word(input int s, input logic [63:0] w);
    send_q[s].push_back(w);
    exp_q[s].push_back(w);
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += exp_q[i].size();
    return n;
  endfunction

  // One cycle: drive at negedge, observe and score 1 ns later.
  task automatic step();
    logic v;
    logic [1:0] g;
    @(negedge clk);
    reset         = drv_reset;
    pld_fifo_full = drv_full;
    arb_enable    = drv_en;
    for (int i = 0; i < 4; i++) begin
      v = en_mask[i] && (send_q[i].size() > 0);
      src_valid[i] = v;
      src_data[i*64 +: 64] = v ? send_q[i][0] : 64'h0;
    end
    #1;
    g = grant_id;
    if (busy && !busy_prev && exp_grant_q.size() > 0)
      check("grant_order", 64'(g), 64'(exp_grant_q.pop_front()));
    busy_prev = busy;
    if (pld_fifo_wr) begin
      check("wr_while_full", 64'(pld_fifo_full), 64'd0);
      check("rdy_onehot", 64'(src_rdy), 64'(4'b0001 << g));
      check("word_expected", 64'(exp_q[g].size() > 0), 64'd1);
      if (exp_q[g].size() > 0) check("din", pld_fifo_din, exp_q[g].pop_front());
      if (burst_cnt == 0) burst_src = g;
      else check("contiguous", 64'(g), 64'(burst_src));
      burst_cnt = (burst_cnt + 1) % 2;
    end else if (src_rdy != 4'b0) begin
      check("rdy_without_wr", 64'(src_rdy), 64'd0);
    end
    for (int i = 0; i < 4; i++) if (src_rdy[i]) void'(send_q[i].pop_front());
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    step();
    step();
    drv_reset = 1'b0;
    burst_cnt = 0;
    busy_prev = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((pending() > 0 || exp_grant_q.size() > 0) && k < 200) begin
      step();
      k++;
    end
    check(tag, 64'(pending() + exp_grant_q.size()), 64'd0);
    step();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  int          seq_src [3];
  int          exp_seq [3];
  int          r_writes;
  int          tag;

  initial begin
    n_checks = 0; n_pass = 0;
    en_mask = 4'hF; drv_full = 1'b0; drv_en = 1'b1; drv_reset = 1'b1;
    busy_prev = 1'b0; burst_cnt = 0; burst_src = 2'd0;
    reset = 1'b1; src_valid = '0; src_data = '0; arb_enable = 1'b1; pld_fifo_full = 1'b0;
    r_reset = 1'b1; r_valid = '0; r_data = '0; r_full = 1'b0;

    // Reset state
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr", 64'(pld_fifo_wr), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_rdy", 64'(src_rdy), 64'd0);
    check("rst_din", pld_fifo_din, 64'd0);
    check("rst_records", 64'(records_granted), 64'd0);
    check("rst_stalls", 64'(stall_cycles), 64'd0);

    // Source 0 alone: one IDLE cycle then A0, A1 back to back
    push_word(0, 64'hA0); push_word(0, 64'hA1);
    exp_grant_q.push_back(2'd0);
    step();
    check("t1_idle_wr", 64'(pld_fifo_wr), 64'd0);
    step();
    check("t1_w0_wr", 64'(pld_fifo_wr), 64'd1);
    step();
    check("t1_w1_wr", 64'(pld_fifo_wr), 64'd1);
    step();
    check("t1_back_idle", 64'(busy), 64'd0);
    check("t1_grant", 64'(grant_id), 64'd0);

    // All sources valid: strict rotation 0,1,2,3,0,1,2,3
    do_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) push_word(s, (64'(s) << 56) | 64'(k));
    for (int r = 0; r < 8; r++) exp_grant_q.push_back(2'(r % 4));
    drain("t2_rotation");

    // Backpressure on source 2 after its first word
    do_reset();
    push_word(2, 64'hC0); push_word(2, 64'hC1);
    exp_grant_q.push_back(2'd2);
    step();
    step();
    check("t3_w0_wr", 64'(pld_fifo_wr), 64'd1);
    drv_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_stall_wr", 64'(pld_fifo_wr), 64'd0);
      check("t3_stall_rdy", 64'(src_rdy), 64'd0);
      check("t3_stall_busy", 64'(busy), 64'd1);
    end
    drv_full = 1'b0;
    step();
    check("t3_resume_wr", 64'(pld_fifo_wr), 64'd1);
    step();
    check("t3_done", 64'(busy), 64'd0);
    check("t3_stall_cycles", 64'(stall_cycles), STATS ? 64'd3 : 64'd0);
    check("t3_records", 64'(records_granted), STATS ? 64'd1 : 64'd0);

    // Source 1 gaps mid-record while source 3 waits
    do_reset();
    push_word(1, 64'hB0); push_word(1, 64'hB1);
    push_word(3, 64'hD0); push_word(3, 64'hD1);
    exp_grant_q.push_back(2'd1); exp_grant_q.push_back(2'd3);
    step();
    step();
    check("t4_b0_wr", 64'(pld_fifo_wr), 64'd1);
    en_mask[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_gap_wr", 64'(pld_fifo_wr), 64'd0);
      check("t4_gap_grant", 64'(grant_id), 64'd1);
    end
    en_mask = 4'hF;
    step();
    check("t4_b1_wr", 64'(pld_fifo_wr), 64'd1);
    step();
    step();
    check("t4_d0_grant", 64'(grant_id), 64'd3);
    drain("t4_drain");

    // Enable low blocks grants; reset mid-burst abandons the record
    do_reset();
    drv_en = 1'b0;
    push_word(2, 64'hE0); push_word(2, 64'hE1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_disabled_busy", 64'(busy), 64'd0);
    end
    drv_en = 1'b1;
    exp_grant_q.push_back(2'd2);
    step();
    step();
    check("t5_e0_wr", 64'(pld_fifo_wr), 64'd1);
    drv_reset = 1'b1;
    step();
    check("t5_rst_wr", 64'(pld_fifo_wr), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_din", pld_fifo_din, 64'd0);
    drv_reset = 1'b0; burst_cnt = 0; busy_prev = 1'b0;
    push_word(0, 64'hF0); push_word(0, 64'hF1); push_word(2, 64'hE2);
    exp_grant_q.push_back(2'd0); exp_grant_q.push_back(2'd2);
    step();
    check("t5_post_busy", 64'(busy), 64'd0);
    check("t5_post_grant", 64'(grant_id), 64'd0);
    drain("t5_drain");

    // Randomized NUM_SRC=3, BURST_WORDS=1 instance: no lost or duplicated words
    for (int i = 0; i < 3; i++) begin seq_src[i] = 0; exp_seq[i] = 0; end
    r_writes = 0;
    repeat (2) @(negedge clk);
    r_reset = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        r_valid[i] = 1'($urandom_range(0, 1));
        r_data[i*64 +: 64] = (64'(i) << 56) | 64'(seq_src[i]);
      end
      r_full = ($urandom_range(0, 3) == 0);
      #1;
      if (r_wr) begin
        tag = int'(r_din[63:56]);
        check("r_wr_while_full", 64'(r_full), 64'd0);
        check("r_src_tag", 64'(tag < 3), 64'd1);
        if (tag < 3) begin
          check("r_rdy", 64'(r_rdy), 64'(3'b001 << tag));
          check("r_seq", 64'(r_din[55:0]), 64'(exp_seq[tag]));
          exp_seq[tag]++;
        end
        r_writes++;
      end else if (r_rdy != 3'b0) begin
        check("r_rdy_without_wr", 64'(r_rdy), 64'd0);
      end
      for (int i = 0; i < 3; i++) if (r_rdy[i]) seq_src[i]++;
    end
    check("r_progress", 64'(r_writes > 1000), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
